// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
// Turns single-register access requests into the RTC multiplexed-bus strobe
// sequence and the phase flags used by the downstream data mux stage.
// Every transaction walks seven phases of T_PHASE cycles each.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for START; ADRESS holds the last accepted address
// A_SET | address setup: CS_n low, AD=0, address driven
// A_STB | address strobe: WR_n low latches the address into the RTC
// A_HLD | address hold after the strobe
// D_SET | data setup: AD=1, write data driven on writes
// D_STB | data strobe: WR_n (write) or RD_n (read) low
// D_HLD | data hold, strobes released
// REC   | recovery with CS_n high; DONE on the final cycle
//
// Ports:
//   CLK, RST (async, active low)      clock / reset
//   START, WRITE, ADDR_in             request and its attributes
//   BUSY, DONE                        transaction status
//   ADRESS                            latched register address
//   BEnv_Adress, BEnv_Data, BRes_Data phase flags for the mux stage
//   CS_n, RD_n, WR_n, AD              RTC bus strobes
module rtc_bus_sequencer #(
  parameter int unsigned T_PHASE = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       WRITE,
  input  logic [7:0] ADDR_in,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] ADRESS,
  output logic       BEnv_Adress,
  output logic       BEnv_Data,
  output logic       BRes_Data,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       AD
);

  typedef enum logic [2:0] {
    IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, REC
  } state_t;

  localparam logic [7:0] TC = 8'(T_PHASE - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] adress_q, adress_d;
  logic       wr_latch_q, wr_latch_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       benv_a_q, benv_a_d, benv_d_q, benv_d_d, bres_q, bres_d;
  logic       cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, ad_q, ad_d;
  logic       last_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adress_d   = adress_q;
    wr_latch_d = wr_latch_q;
    if (state_q == IDLE) begin
      if (START) begin
        state_d    = A_SET;
        cnt_d      = 8'd0;
        adress_d   = ADDR_in;
        wr_latch_d = WRITE;
      end
    end else if (cnt_q == TC) begin
      cnt_d = 8'd0;
      case (state_q)
        A_SET:   state_d = A_STB;
        A_STB:   state_d = A_HLD;
        A_HLD:   state_d = D_SET;
        D_SET:   state_d = D_STB;
        D_STB:   state_d = D_HLD;
        D_HLD:   state_d = REC;
        default: state_d = IDLE;
      endcase
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Outputs are decoded from the next state/count so that the registered
  // values line up with the cycle the state is actually entered.
  always_comb begin
    last_d   = (cnt_d == TC);
    busy_d   = (state_d != IDLE);
    done_d   = 1'b0;
    benv_a_d = 1'b0;
    benv_d_d = 1'b0;
    bres_d   = 1'b0;
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_d     = 1'b1;
    case (state_d)
      A_SET: begin
        cs_n_d = 1'b0; ad_d = 1'b0; benv_a_d = 1'b1;
      end
      A_STB: begin
        cs_n_d = 1'b0; ad_d = 1'b0; benv_a_d = 1'b1; wr_n_d = 1'b0;
      end
      A_HLD: begin
        cs_n_d = 1'b0; ad_d = 1'b0; benv_a_d = 1'b1;
      end
      D_SET, D_HLD: begin
        cs_n_d = 1'b0; benv_d_d = wr_latch_d;
      end
      D_STB: begin
        cs_n_d = 1'b0;
        if (wr_latch_d) begin
          wr_n_d   = 1'b0;
          benv_d_d = 1'b1;
        end else begin
          rd_n_d = 1'b0;
          bres_d = last_d;
        end
      end
      REC:     done_d = last_d;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      adress_q   <= 8'h00;
      wr_latch_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      benv_a_q   <= 1'b0;
      benv_d_q   <= 1'b0;
      bres_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      ad_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adress_q   <= adress_d;
      wr_latch_q <= wr_latch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      benv_a_q   <= benv_a_d;
      benv_d_q   <= benv_d_d;
      bres_q     <= bres_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      ad_q       <= ad_d;
    end
  end

  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ADRESS      = adress_q;
  assign BEnv_Adress = benv_a_q;
  assign BEnv_Data   = benv_d_q;
  assign BRes_Data   = bres_q;
  assign CS_n        = cs_n_q;
  assign RD_n        = rd_n_q;
  assign WR_n        = wr_n_q;
  assign AD          = ad_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Testbench for rtc_bus_sequencer: one instance with T_PHASE=4, one with
// T_PHASE=1. Expected bus activity comes from a phase/offset model of the
// seven-phase transaction, checked every cycle.
module tb_rtc_bus_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] adress;
    logic       benv_a;
    logic       benv_d;
    logic       bres;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, write_r;
  logic [7:0] addr;
  logic       sel;

  logic       st4, st1;
  logic       busy4, done4, ba4, bd4, br4, cs4, rd4, wr4, ad4;
  logic       busy1, done1, ba1, bd1, br1, cs1, rd1, wr1, ad1;
  logic [7:0] adr4, adr1;
  outs_t      obs;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_a [2];

  always #5 clk = ~clk;

  assign st4 = start & ~sel;
  assign st1 = start & sel;

  rtc_bus_sequencer #(.T_PHASE(4)) dut4 (
    .CLK(clk), .RST(rst_n), .START(st4), .WRITE(write_r), .ADDR_in(addr),
    .BUSY(busy4), .DONE(done4), .ADRESS(adr4), .BEnv_Adress(ba4),
    .BEnv_Data(bd4), .BRes_Data(br4), .CS_n(cs4), .RD_n(rd4), .WR_n(wr4),
    .AD(ad4));

  rtc_bus_sequencer #(.T_PHASE(1)) dut1 (
    .CLK(clk), .RST(rst_n), .START(st1), .WRITE(write_r), .ADDR_in(addr),
    .BUSY(busy1), .DONE(done1), .ADRESS(adr1), .BEnv_Adress(ba1),
    .BEnv_Data(bd1), .BRes_Data(br1), .CS_n(cs1), .RD_n(rd1), .WR_n(wr1),
    .AD(ad1));

  always_comb begin
    if (sel) obs = '{busy1, done1, adr1, ba1, bd1, br1, cs1, rd1, wr1, ad1};
    else     obs = '{busy4, done4, adr4, ba4, bd4, br4, cs4, rd4, wr4, ad4};
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Exclusion rules hold at all times on both instances.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("excl_rdwr4", 32'(!rd4 && !wr4), 32'd0);
      chk("excl_benv4", 32'(ba4 && bd4), 32'd0);
      chk("excl_rdwr1", 32'(!rd1 && !wr1), 32'd0);
      chk("excl_benv1", 32'(ba1 && bd1), 32'd0);
    end
  end

  function automatic outs_t idle_exp(input logic [7:0] a);
    outs_t e;
    e = '{1'b0, 1'b0, a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    return e;
  endfunction

  // Cycle k (1..7T) after the accepting edge: phase = (k-1)/T, and the
  // last cycle of a phase is offset T-1.
  function automatic outs_t exp_at(input int k, input int t, input bit wr, input logic [7:0] a);
    outs_t e;
    int ph;
    bit last;
    ph   = (k - 1) / t;
    last = ((k - 1) % t) == (t - 1);
    e = idle_exp(a);
    e.busy = 1'b1;
    if (ph <= 2) begin
      e.cs_n = 1'b0; e.ad = 1'b0; e.benv_a = 1'b1;
      e.wr_n = (ph == 1) ? 1'b0 : 1'b1;
    end else if (ph <= 5) begin
      e.cs_n = 1'b0;
      e.benv_d = wr;
      if (ph == 4) begin
        if (wr) e.wr_n = 1'b0;
        else begin
          e.rd_n = 1'b0;
          e.bres = last;
        end
      end
    end else begin
      e.done = last;
    end
    return e;
  endfunction

  task automatic run_txn(input int t, input bit wr, input logic [7:0] a,
                         input int ig0, input int ig1, input int ig2);
    int dones;
    dones = 0;
    @(posedge clk); #1;
    start = 1'b1; write_r = wr; addr = a;
    @(negedge clk);
    chk("pre_idle", 32'(obs), 32'(idle_exp(last_a[sel])));
    for (int k = 1; k <= 7 * t; k++) begin
      @(posedge clk); #1;
      start   = (k == ig0 || k == ig1 || k == ig2);
      write_r = 1'($urandom);
      addr    = 8'($urandom);
      @(negedge clk);
      chk($sformatf("t%0d_wr%0d_cyc%0d", t, wr, k), 32'(obs), 32'(exp_at(k, t, wr, a)));
      if (obs.done) dones++;
    end
    last_a[sel] = a;
    chk("done_count", 32'(dones), 32'd1);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("gap_idle", 32'(obs), 32'(idle_exp(last_a[sel])));
    end
  endtask

  initial begin
    sel = 1'b0; rst_n = 1'b0; start = 1'b1; write_r = 1'b1; addr = 8'hFF;
    last_a[0] = 8'h00; last_a[1] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset4", 32'(obs), 32'(idle_exp(8'h00)));
    sel = 1'b1; #1;
    chk("reset1", 32'(obs), 32'(idle_exp(8'h00)));
    sel = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;

    run_txn(4, 1'b1, 8'h23, -1, -1, -1);
    gap(1);
    run_txn(4, 1'b0, 8'h41, -1, -1, -1);
    run_txn(4, 1'($urandom), 8'($urandom), 3, 15, 28);
    for (int n = 0; n < 4; n++) begin
      gap(int'($urandom_range(0, 2)));
      run_txn(4, 1'($urandom), 8'($urandom), int'($urandom_range(1, 28)),
              int'($urandom_range(1, 28)), 28);
    end

    // Abort a write while its data strobe is active.
    @(posedge clk); #1;
    start = 1'b1; write_r = 1'b1; addr = 8'h5A;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    chk("pre_abort_wr_n", 32'(obs.wr_n), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_async", 32'(obs), 32'(idle_exp(8'h00)));
    last_a[0] = 8'h00; last_a[1] = 8'h00;
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold", 32'(obs), 32'(idle_exp(8'h00)));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    gap(2);
    run_txn(4, 1'b1, 8'hC3, -1, -1, -1);

    // T_PHASE = 1: back-to-back reads, then random traffic.
    gap(1);
    sel = 1'b1;
    run_txn(1, 1'b0, 8'h11, -1, -1, -1);
    run_txn(1, 1'b0, 8'h12, 7, -1, -1);
    for (int n = 0; n < 6; n++) begin
      gap(int'($urandom_range(0, 2)));
      run_txn(1, 1'($urandom), 8'($urandom), int'($urandom_range(1, 7)), -1, 7);
    end
    gap(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
